// File: rtl/eight_bit_16_reg_scanner.sv
// Sixteen-entry 8-bit register bank feeding an external 16:1 mux, plus a scan
// FSM that walks the selects and streams the returned word out as valid/ready.
// Optional build macro: SCAN_SKIP_ZERO_EN (suppress 0x00 words during a scan).

module scan_reg_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wd,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= 8'h00;
    else if (wr) q <= wd;
  end
endmodule

module eight_bit_16_reg_scanner #(
  parameter int SCAN_LAST = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] q0,
  output logic [7:0] q1,
  output logic [7:0] q2,
  output logic [7:0] q3,
  output logic [7:0] q4,
  output logic [7:0] q5,
  output logic [7:0] q6,
  output logic [7:0] q7,
  output logic [7:0] q8,
  output logic [7:0] q9,
  output logic [7:0] q10,
  output logic [7:0] q11,
  output logic [7:0] q12,
  output logic [7:0] q13,
  output logic [7:0] q14,
  output logic [7:0] q15,
  input  logic       start,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  input  logic [7:0] mux_out,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       done
);
  localparam int          NUM_REGS = 16;
  localparam logic [3:0]  LAST     = 4'(SCAN_LAST);
`ifdef SCAN_SKIP_ZERO_EN
  localparam logic        SKIP_ZERO = 1'b1;
`else
  localparam logic        SKIP_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_OUT, S_DONE} state_t;

  state_t                          state, state_nxt;
  logic [3:0]                      idx;
  logic [NUM_REGS-1:0][7:0]        q_bank;
  logic                            skip, at_last, xfer;

  // Register bank: one slot per mux input.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    scan_reg_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en && (wr_addr == 4'(i))),
      .wd    (wr_data),
      .q     (q_bank[i])
    );
  end

  assign q0  = q_bank[0];
  assign q1  = q_bank[1];
  assign q2  = q_bank[2];
  assign q3  = q_bank[3];
  assign q4  = q_bank[4];
  assign q5  = q_bank[5];
  assign q6  = q_bank[6];
  assign q7  = q_bank[7];
  assign q8  = q_bank[8];
  assign q9  = q_bank[9];
  assign q10 = q_bank[10];
  assign q11 = q_bank[11];
  assign q12 = q_bank[12];
  assign q13 = q_bank[13];
  assign q14 = q_bank[14];
  assign q15 = q_bank[15];

  assign skip    = SKIP_ZERO && (mux_out == 8'h00);
  assign at_last = (idx == LAST);
  assign xfer    = (state == S_OUT) && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEL;
      S_SEL:  if (!skip) state_nxt = S_OUT;
              else if (at_last) state_nxt = S_DONE;
      S_OUT:  if (dout_ready) state_nxt = at_last ? S_DONE : S_SEL;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    dout_valid = (state == S_OUT);
    {s3, s2, s1, s0} = idx;
  end

  // Index only advances inside a scan and saturates at LAST; it is
  // cleared on the way back through IDLE.
  always_ff @(posedge clk) begin
    if (reset)                                    idx <= 4'd0;
    else if (state == S_IDLE || state == S_DONE)  idx <= 4'd0;
    else if (xfer && !at_last)                    idx <= idx + 4'd1;
    else if (state == S_SEL && skip && !at_last)  idx <= idx + 4'd1;
  end

  // Capture samples the pre-edge bank, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (reset)                          dout <= 8'h00;
    else if (state == S_SEL && !skip)   dout <= mux_out;
  end

endmodule

// File: tb/tb_eight_bit_16_reg_scanner.sv
// Directed bench: default-depth scanner plus a SCAN_LAST=2 instance, each
// driven through a behavioral 16:1 mux built from its own q outputs.
module tb_eight_bit_16_reg_scanner;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // ---------- DUT A (SCAN_LAST = 15) ----------
  logic       wr_en = 0, start = 0, dout_ready = 0;
  logic [3:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] q0,q1,q2,q3,q4,q5,q6,q7,q8,q9,q10,q11,q12,q13,q14,q15;
  logic       s0, s1, s2, s3, dout_valid, busy, done;
  logic [7:0] dout, mux_out;
  logic [15:0][7:0] qa;
  logic [3:0] sel;
  assign qa = {q15,q14,q13,q12,q11,q10,q9,q8,q7,q6,q5,q4,q3,q2,q1,q0};
  assign sel = {s3, s2, s1, s0};
  assign mux_out = qa[sel];

  eight_bit_16_reg_scanner dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .q8(q8), .q9(q9), .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15),
    .start(start), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .mux_out(mux_out),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done));

  // ---------- DUT B (SCAN_LAST = 2) ----------
  logic       wr_en2 = 0, start2 = 0, dout_ready2 = 0;
  logic [3:0] wr_addr2 = 0;
  logic [7:0] wr_data2 = 0;
  logic [7:0] r0,r1,r2,r3,r4,r5,r6,r7,r8,r9,r10,r11,r12,r13,r14,r15;
  logic       t0, t1, t2, t3, dout_valid2, busy2, done2;
  logic [7:0] dout2, mux_out2;
  logic [15:0][7:0] ra;
  logic [3:0] sel2;
  assign ra = {r15,r14,r13,r12,r11,r10,r9,r8,r7,r6,r5,r4,r3,r2,r1,r0};
  assign sel2 = {t3, t2, t1, t0};
  assign mux_out2 = ra[sel2];

  eight_bit_16_reg_scanner #(.SCAN_LAST(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .q0(r0), .q1(r1), .q2(r2), .q3(r3), .q4(r4), .q5(r5), .q6(r6), .q7(r7),
    .q8(r8), .q9(r9), .q10(r10), .q11(r11), .q12(r12), .q13(r13), .q14(r14), .q15(r15),
    .start(start2), .s0(t0), .s1(t1), .s2(t2), .s3(t3), .mux_out(mux_out2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_scan();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_out(input logic [3:0] idx);
    int n = 0;
    while (!(dout_valid && sel == idx) && n < 100) begin tick(); n++; end
    chk("wait_out_timeout", 32'(n < 100), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("wait_done_timeout", 32'(n < 200), 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d; tick(); wr_en = 0;
  endtask

  initial begin
    int n, nw, ndone;
    logic [7:0] w [4];

    // Reset state
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_q0", q0, 0); chk("rst_q15", q15, 0); chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_sel", sel, 0);

    // Load bank and full scan with ready held high
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
    chk("wr_q5", q5, 8'h15); chk("wr_q15", q15, 8'h1f);
    dout_ready = 1;
    start_scan();
    chk("scan_sel0_busy", busy, 1); chk("scan_sel0_valid", dout_valid, 0);
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("scan_valid", dout_valid, 1);
      chk("scan_dout", dout, 32'(8'h10 + k));
      chk("scan_sel", sel, 32'(k));
      tick();
      if (k < 15) chk("scan_gap_valid", dout_valid, 0);
      else        chk("scan_done_pulse", done, 1);
      ndone += (k < 15 && done) ? 1 : 0;
    end
    tick();
    chk("scan_done_low", done, 0); chk("scan_idle", busy, 0);
    chk("scan_done_early", ndone, 0);

    // Backpressure on index 3
    start_scan();
    wait_out(3);
    dout_ready = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_dout", dout, 8'h13); chk("hold_valid", dout_valid, 1);
      chk("hold_sel", sel, 3);
    end
    dout_ready = 1;
    tick(); chk("rel_sel4", sel, 4); chk("rel_gap", dout_valid, 0);
    tick(); chk("rel_dout14", dout, 8'h14); chk("rel_valid", dout_valid, 1);
    wait_done();
    tick(); chk("bp_idle", busy, 0);

    // Write on the capture edge of index 5 returns the old value
    start_scan();
    wait_out(4);
    tick(); chk("cap_sel5", sel, 5);
    wr_en = 1; wr_addr = 5; wr_data = 8'h55;
    tick(); wr_en = 0;
    chk("cap_old", dout, 8'h15); chk("cap_q5", q5, 8'h55);
    dout_ready = 0;
    wr(5, 8'h66);
    chk("out_wr_dout", dout, 8'h15); chk("out_wr_q5", q5, 8'h66);
    wr(5, 8'h55);
    dout_ready = 1;
    wait_done();
    tick();
    start_scan();
    wait_out(5);
    chk("rescan_q5", dout, 8'h55);
    wait_done();
    tick();

    // Reset mid-scan in OUT at index 7
    start_scan();
    wait_out(7);
    dout_ready = 0;
    reset = 1; tick(); reset = 0;
    chk("mid_rst_q7", q7, 0); chk("mid_rst_q0", q0, 0);
    chk("mid_rst_valid", dout_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", sel, 0); chk("mid_rst_dout", dout, 0);
    dout_ready = 1;
    start_scan();
    chk("restart_sel", sel, 0); chk("restart_busy", busy, 1);
`ifndef SCAN_SKIP_ZERO_EN
    tick();
    chk("zero_word_valid", dout_valid, 1); chk("zero_word_dout", dout, 0);
    wait_done();
    tick();
`else
    // All-zero bank: done after SCAN_LAST+1 SEL cycles, no words
    n = 0; nw = 0;
    while (!done && n < 100) begin tick(); n++; nw += dout_valid ? 1 : 0; end
    chk("skip_all_edges", n, 16); chk("skip_all_words", nw, 0);
    tick();
    wr(4, 8'h44); wr(9, 8'h99);
    start_scan();
    n = 0; nw = 0;
    while (!done && n < 100) begin
      if (dout_valid && nw < 4) begin w[nw] = dout; nw++; end
      tick(); n++;
    end
    chk("skip_words", nw, 2); chk("skip_w0", w[0], 8'h44);
    chk("skip_w1", w[1], 8'h99); chk("skip_done", done, 1);
    tick();
`endif

    // SCAN_LAST=2 instance: three words, start mid-scan ignored
    for (int i = 0; i < 3; i++) begin
      wr_en2 = 1; wr_addr2 = 4'(i); wr_data2 = 8'(8'hA0 + i); tick();
    end
    wr_en2 = 0;
    dout_ready2 = 1;
    start2 = 1; tick(); start2 = 0;
    n = 0; nw = 0;
    while (!done2 && n < 100) begin
      if (dout_valid2 && nw < 4) begin w[nw] = dout2; nw++; end
      start2 = (n == 2);
      tick(); n++;
    end
    start2 = 0;
    chk("l2_edges", n, 6); chk("l2_words", nw, 3);
    chk("l2_w0", w[0], 8'hA0); chk("l2_w1", w[1], 8'hA1); chk("l2_w2", w[2], 8'hA2);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin tick(); ndone += (busy2 || dout_valid2) ? 1 : 0; end
    chk("l2_no_rescan", ndone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eight_bit_16_reg_scanner.md
# eight_bit_16_reg_scanner

Upstream feeder for the 8-bit 16:1 mux stage. Holds sixteen 8-bit registers whose outputs drive the mux's sixteen data inputs, and generates the mux selects s0..s3 from a scan state machine. The selected word returns on `mux_out` and is emitted as a valid/ready stream. One scan walks indices 0..SCAN_LAST once and then signals completion.

## Interface
Parameters:
- SCAN_LAST, default 15: last index visited by a scan; 4-bit value, legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- wr_en  input  1  write strobe for the register bank.
- wr_addr  input  4  register index to write.
- wr_data  input  8  write data.
- q0..q15  output  8 each  register contents; q0 drives mux input a, through q15 driving mux input p.
- start  input  1  begins a scan when sampled high in IDLE.
- s0, s1, s2, s3  output  1 each  mux select; {s3,s2,s1,s0} = current index.
- mux_out  input  8  selected word returned from the mux.
- dout  output  8  emitted word.
- dout_valid  output  1  dout holds a word awaiting transfer.
- dout_ready  input  1  downstream accepts dout.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last index is handled.

## Operation
- Register bank: on an edge with wr_en=1, q[wr_addr] <= wr_data. Writes are accepted in every state.
- FSM states:
  - IDLE: index = 0. start=1 -> SEL.
  - SEL: the selects are stable at the current index. On the next edge, dout <= mux_out and the FSM goes to OUT.
  - OUT: dout_valid=1 and dout is held stable.
    - On an edge with dout_ready=1 and index<SCAN_LAST: index+1, FSM -> SEL.
    - On an edge with dout_ready=1 and index==SCAN_LAST: FSM -> DONE.
    - With dout_ready=0 the FSM stays in OUT.
  - DONE: done=1 for exactly one cycle, then IDLE with index=0.
- start is ignored while busy=1.
- A write that lands on the same edge as the SEL capture returns the old value, because capture and write occur on the same edge.
- A write to the index currently held in OUT does not alter dout.
- The index never exceeds SCAN_LAST. There is no wrap within a scan; the index returns to 0 only through IDLE.
- Reset mid-scan aborts the scan and discards the pending word.

## Timing
- Reset values: q0..q15=0x00, s3..s0=0, dout=0x00, dout_valid=0, busy=0, done=0, state IDLE.
- Scan start: start is sampled at edge E. Cycle E+1 is SEL with index 0. Cycle E+2 has dout=q0 and dout_valid=1.
- Each word takes at least 2 cycles (SEL + OUT). With dout_ready held at 1, the last word transfers at edge E+2·(SCAN_LAST+1). done is high in the following cycle, and busy drops one cycle after that.
- A write at edge W is visible on q[wr_addr] from cycle W+1.
- Transfer occurs only on an edge where dout_valid=1 and dout_ready=1. dout_ready has no effect outside OUT.
- Back-to-back scans: the earliest accepted start is in the IDLE cycle after DONE.

## Configuration
- SCAN_SKIP_ZERO_EN defined:
  - In SEL, if mux_out==0x00, no word is emitted. The FSM advances the index and stays in SEL, or goes to DONE if index==SCAN_LAST.
  - An all-zero bank produces no valid words and pulses done after SCAN_LAST+1 SEL cycles.
- SCAN_SKIP_ZERO_EN undefined: every index 0..SCAN_LAST is emitted, including 0x00 words.

## Test plan
- Reset, then write q[i]=0x10+i for all i; start with dout_ready=1 -> stream 0x10..0x1F, one word every 2 cycles, done pulses once, busy=0 afterwards.
- Hold dout_ready=0 for 5 cycles on index 3 -> dout=0x13 and dout_valid remain stable, and the selects hold 3. Release -> the stream continues with 0x14.
- SCAN_LAST=2, q0..q2=0xA0,0xA1,0xA2 -> exactly 3 words, then done. Pulse start during the scan -> ignored, no second scan.
- Write q5=0x55 on the capture edge of index 5 (old value 0x15) -> dout=0x15. Rescan -> dout=0x55 at index 5.
- Assert reset while in OUT at index 7 -> next cycle: all q=0x00, dout_valid=0, busy=0, selects 0. A new start scans from index 0.
- With SCAN_SKIP_ZERO_EN and only q4=0x44 and q9=0x99 nonzero -> exactly two words (0x44, then 0x99), followed by done.
